dummy_tcdm_memory: RTL and testbench
====================================

Name: dummy_tcdm_memory

Overview:
Multi-port, word-oriented TCDM memory model used as instruction, stack and shared-data memory around the redmule_complex accelerator cluster. It serves MP independent hwpe_stream_intf_tcdm slave ports from a single preloadable byte array. Grants are combinational and can be randomly stalled. Responses arrive with one-cycle latency. Per-port read and write counters support bandwidth reporting.

Parameters:
MP, 1, number of TCDM slave ports.
MEMORY_SIZE, 192*1024, memory size in bytes; the array `memory` is MEMORY_SIZE x 8 bit and is preloadable by $readmemh.
BASE_ADDR, 32'h1c000000, byte address mapped to memory[0].
PROB_STALL, 0, grant-stall probability in percent (0..100).
TCP, 1ns, clock period; simulation timing only, no functional effect.
TA, 0.2ns, application time; simulation timing only, no functional effect.
TT, 0.8ns, test time; simulation timing only, no functional effect.

Ports:
clk_i  in  1  single clock; all state updates on the rising edge.
rst_ni  in  1  synchronous active-low reset.
clk_delayed_i  in  1  reserved; ignored.
randomize_i  in  1  when 1, read data is replaced by pseudo-random data.
enable_i  in  1  when 0, the memory ignores all requests.
stallable_i  in  1  when 1, random grant stalls are permitted.
tcdm[MP].req  in  1  request.
tcdm[MP].add  in  32  byte address.
tcdm[MP].wen  in  1  1 = read, 0 = write.
tcdm[MP].be  in  4  byte enables.
tcdm[MP].data  in  32  write data.
tcdm[MP].gnt  out  1  grant.
tcdm[MP].r_data  out  32  response data.
tcdm[MP].r_valid  out  1  response valid.

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - r_valid=0 and r_data=0 on all ports.
  - cnt_rd[i]=0 and cnt_wr[i]=0.
  - Stall LFSRs load the seed 32'hACE1 + i.
  - Memory contents are NOT cleared; preloaded data survives reset.
- Stall generation:
  - Each port i has a 32-bit Galois LFSR (polynomial 0x80200003) that advances every cycle when not in reset.
  - stall[i] = stallable_i & ((lfsr[i] % 100) < PROB_STALL).
  - PROB_STALL=0: never stalls. PROB_STALL=100 with stallable_i=1: never grants.
- Grant (combinational): gnt[i] = enable_i & req[i] & ~stall[i].
- Address mapping:
  - off = (add - BASE_ADDR) mod 2^32, then bits [1:0] forced to 0 (word-aligned).
  - If off + 3 >= MEMORY_SIZE the access is out of range: writes are dropped and reads return 32'h0.
- Byte order: little-endian. Byte k of data/r_data maps to memory[off+k].
- Write (granted, wen=0):
  - Bytes with be[k]=1 are written at the rising edge.
  - Bytes with be[k]=0 are unchanged.
  - cnt_wr[i] increments by 1.
- Read (granted, wen=1): cnt_rd[i] increments by 1.
- Response timing:
  - In the cycle after any grant (read or write), r_valid[i]=1.
  - r_data[i] = word contents sampled at the grant edge, i.e. pre-write contents for that edge; for writes, r_data = pre-write word.
  - r_valid=0 in every other cycle; r_data holds its last value.
- randomize_i=1 at the grant edge: r_data = current lfsr[i] value instead of memory contents.
- Simultaneous accesses in one cycle:
  - Two ports writing the same byte: the higher port index wins.
  - A read and a write to the same word on different ports: the read returns the old data.
- Back-to-back requests are allowed: one grant per port per cycle, full throughput.
- enable_i=0 forces gnt=0. Responses to grants issued in the previous cycle still complete.
- Counters are 32-bit, wrap at 2^32, and are readable hierarchically as cnt_rd[0..MP-1] / cnt_wr[0..MP-1].

Test Plan:
- Preload memory with bytes 00,01,02,03 at offset 0, MP=1, BASE_ADDR=32'h1c000000. Read add=32'h1c000000 -> gnt=1 same cycle; next cycle r_valid=1, r_data=32'h03020100; cnt_rd[0]=1.
- Write data=32'hAABBCCDD, be=4'b0101 at 32'h1c000000, then read the same address -> r_data=32'h03BB01DD; first response carries r_data=32'h03020100; cnt_wr[0]=1.
- MP=9 with DW-style striping: port ii reads add=32'h1c010000+4*ii, all granted together -> all nine r_valid high in the same cycle, each returning its own word.
- PROB_STALL=100, stallable_i=1: req held 10 cycles -> gnt=0 throughout. Drop stallable_i to 0 -> granted in the same cycle.
- Port 0 and port 1 write 32'h11111111 and 32'h22222222 to the same word in one cycle -> subsequent read returns 32'h22222222.
- Preload memory, assert reset mid-read -> r_valid=0 and counters 0 after reset; a subsequent read still returns the preloaded word. An out-of-range read (add=BASE_ADDR+MEMORY_SIZE) returns 32'h0.

Source files
------------

// File: rtl/dummy_tcdm_memory.sv
// Multi-port word-oriented TCDM memory model over one preloadable byte array.
// Combinational grants with optional LFSR-driven stalls, one-cycle responses, per-port traffic counters.
module dummy_tcdm_memory #(
    parameter int          MP          = 1,
    parameter int          MEMORY_SIZE = 192*1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1c000000,
    parameter int          PROB_STALL  = 0,
    parameter real         TCP         = 1.0,
    parameter real         TA          = 0.2,
    parameter real         TT          = 0.8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clk_delayed_i,
    input  logic                 randomize_i,
    input  logic                 enable_i,
    input  logic                 stallable_i,
    input  logic [MP-1:0]        tcdm_req,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][3:0]   tcdm_be,
    input  logic [MP-1:0][31:0]  tcdm_data,
    output logic [MP-1:0]        tcdm_gnt,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic [MP-1:0]        tcdm_r_valid
);

    localparam int          AW        = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [31:0] POLY      = 32'h80200003;
    localparam logic [31:0] SEED      = 32'hACE1;
    localparam logic [31:0] MEM_BYTES = 32'(MEMORY_SIZE);

    logic [7:0]    memory  [MEMORY_SIZE];
    logic [31:0]   cnt_rd  [MP];
    logic [31:0]   cnt_wr  [MP];
    logic [31:0]   lfsr    [MP];

    logic [31:0]   off      [MP];
    logic [AW-1:0] idx      [MP];
    logic [6:0]    lfsr_mod [MP];
    logic [31:0]   rd_word  [MP];
    logic [MP-1:0] in_range;
    logic [MP-1:0] stall;

    // Timing parameters and the delayed clock only matter to the original behavioural model.
    logic unused_ok;
    assign unused_ok = clk_delayed_i | (TCP < 0.0) | (TA < 0.0) | (TT < 0.0);

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    always_comb begin
        for (int i = 0; i < MP; i++) begin
            // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
            off[i]      = (tcdm_add[i] - BASE_ADDR) & ~32'd3;
            in_range[i] = (off[i] + 32'd3) < MEM_BYTES;
            idx[i]      = off[i][AW-1:0];
            lfsr_mod[i] = 7'(lfsr[i] % 32'd100);
            stall[i]    = stallable_i && (int'({25'd0, lfsr_mod[i]}) < PROB_STALL);
            tcdm_gnt[i] = enable_i & tcdm_req[i] & ~stall[i];
            rd_word[i]  = 32'h0;
            if (in_range[i]) begin
                for (int k = 0; k < 4; k++) begin
                    rd_word[i][8*k +: 8] = memory[idx[i] + AW'(k)];
                end
            end
        end
    end

    // NOTE: the memory array has no reset so preloaded contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            // Ascending port order lets the highest-index writer win a byte collision.
            for (int i = 0; i < MP; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (tcdm_gnt[i] && !tcdm_wen[i] && in_range[i] && tcdm_be[i][k]) begin
                        memory[idx[i] + AW'(k)] <= tcdm_data[i][8*k +: 8];
                    end
                end
            end
        end
    end

    // NOTE: non-blocking updates make r_data capture the pre-write word of the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tcdm_r_valid <= '0;
            tcdm_r_data  <= '0;
            for (int i = 0; i < MP; i++) begin
                cnt_rd[i] <= 32'h0;
                cnt_wr[i] <= 32'h0;
                lfsr[i]   <= SEED + 32'(i);
            end
        end else begin
            for (int i = 0; i < MP; i++) begin
                lfsr[i]         <= lfsr_next(lfsr[i]);
                tcdm_r_valid[i] <= tcdm_gnt[i];
                if (tcdm_gnt[i]) begin
                    tcdm_r_data[i] <= randomize_i ? lfsr[i] : rd_word[i];
                    if (tcdm_wen[i]) begin
                        cnt_rd[i] <= cnt_rd[i] + 32'd1;
                    end else begin
                        cnt_wr[i] <= cnt_wr[i] + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dummy_tcdm_memory.sv
// Directed bench for dummy_tcdm_memory: a 9-port instance for data paths and
// a single-port always-stalling instance for grant stalls.
module tb_dummy_tcdm_memory;

    localparam int          NP   = 9;
    localparam int          MEM  = 192*1024;
    localparam logic [31:0] BASE = 32'h1c000000;

    logic clk = 1'b0;
    logic rst_n, enable, randomize, stallable, s_stallable;

    logic [NP-1:0]       req, wen, gnt, r_valid;
    logic [NP-1:0][31:0] add, data, r_data;
    logic [NP-1:0][3:0]  be;

    logic        s_req, s_wen, s_gnt, s_r_valid;
    logic [31:0] s_add, s_data, s_r_data;
    logic [3:0]  s_be;

    logic [31:0] lfsr_m;
    logic [31:0] exp_rand;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dummy_tcdm_memory #(.MP(NP), .MEMORY_SIZE(MEM), .BASE_ADDR(BASE), .PROB_STALL(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clk_delayed_i(clk), .randomize_i(randomize),
        .enable_i(enable), .stallable_i(stallable),
        .tcdm_req(req), .tcdm_add(add), .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(data),
        .tcdm_gnt(gnt), .tcdm_r_data(r_data), .tcdm_r_valid(r_valid)
    );

    dummy_tcdm_memory #(.MP(1), .MEMORY_SIZE(1024), .BASE_ADDR(BASE), .PROB_STALL(100)) u_stall (
        .clk_i(clk), .rst_ni(rst_n), .clk_delayed_i(clk), .randomize_i(randomize),
        .enable_i(enable), .stallable_i(s_stallable),
        .tcdm_req(s_req), .tcdm_add(s_add), .tcdm_wen(s_wen), .tcdm_be(s_be), .tcdm_data(s_data),
        .tcdm_gnt(s_gnt), .tcdm_r_data(s_r_data), .tcdm_r_valid(s_r_valid)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Reference for the port-0 LFSR, used to predict randomized read data.
    always @(posedge clk) begin
        if (!rst_n) lfsr_m <= 32'hACE1;
        else        lfsr_m <= lfsr_step(lfsr_m);
    end

    function automatic logic [31:0] stripe_word(input int ii);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(8'h40 + 4*ii + k);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port_op(input int p, input logic is_read, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req[p]  = 1'b1;
        wen[p]  = is_read;
        add[p]  = a;
        be[p]   = b;
        data[p] = d;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; randomize = 1'b0; stallable = 1'b1; s_stallable = 1'b1;
        req = '0; wen = '1; add = '0; be = '1; data = '0;
        s_req = 1'b0; s_wen = 1'b1; s_add = BASE; s_be = 4'hf; s_data = 32'h0;

        for (int k = 0; k < 4; k++) begin
            u_dut.memory[k]         <= 8'(k);
            u_dut.memory[MEM-4+k]   <= 8'(8'h5a + k);
        end
        for (int ii = 0; ii < NP; ii++)
            for (int k = 0; k < 4; k++)
                u_dut.memory[32'h10000 + 4*ii + k] <= 8'(8'h40 + 4*ii + k);

        repeat (2) tick();
        check("reset r_valid", 32'(r_valid), 32'h0);
        check("reset r_data0", r_data[0], 32'h0);
        check("reset cnt_rd0", u_dut.cnt_rd[0], 32'h0);
        check("reset cnt_wr8", u_dut.cnt_wr[8], 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic read
        port_op(0, 1'b1, BASE, 4'hf, 32'h0);
        #1 check("read gnt", 32'(gnt[0]), 32'h1);
        tick();
        check("read r_valid", 32'(r_valid[0]), 32'h1);
        check("read r_data", r_data[0], 32'h03020100);
        check("read cnt_rd", u_dut.cnt_rd[0], 32'h1);
        req = '0;
        tick();
        check("idle r_valid", 32'(r_valid[0]), 32'h0);
        check("idle r_data hold", r_data[0], 32'h03020100);

        // Partial write, then read back
        port_op(0, 1'b0, BASE, 4'b0101, 32'hAABBCCDD);
        tick();
        check("write resp pre-data", r_data[0], 32'h03020100);
        check("write cnt_wr", u_dut.cnt_wr[0], 32'h1);
        port_op(0, 1'b1, BASE, 4'hf, 32'h0);
        tick();
        check("be merge read", r_data[0], 32'h03BB01DD);
        check("cnt_rd after 2", u_dut.cnt_rd[0], 32'h2);
        req = '0;
        tick();

        // All nine ports read striped words together
        for (int ii = 0; ii < NP; ii++) port_op(ii, 1'b1, 32'h1c010000 + 32'(4*ii), 4'hf, 32'h0);
        #1 check("stripe gnt", 32'(gnt), 32'h1ff);
        tick();
        check("stripe r_valid", 32'(r_valid), 32'h1ff);
        for (int ii = 0; ii < NP; ii++) check($sformatf("stripe r_data%0d", ii), r_data[ii], stripe_word(ii));
        req = '0;
        tick();

        // Same-word write collision: higher port wins
        port_op(0, 1'b0, BASE + 32'h100, 4'hf, 32'h11111111);
        port_op(1, 1'b0, BASE + 32'h100, 4'hf, 32'h22222222);
        tick();
        req = '0;
        port_op(0, 1'b1, BASE + 32'h100, 4'hf, 32'h0);
        tick();
        check("collision winner", r_data[0], 32'h22222222);
        req = '0;

        // Read and write of the same word on different ports in one cycle
        port_op(2, 1'b0, BASE + 32'h100, 4'hf, 32'h33333333);
        port_op(3, 1'b1, BASE + 32'h100, 4'hf, 32'h0);
        tick();
        check("rw r_valid", 32'(r_valid), 32'h00c);
        check("rw read old", r_data[3], 32'h22222222);
        req = '0;
        port_op(0, 1'b1, BASE + 32'h100, 4'hf, 32'h0);
        tick();
        check("rw write landed", r_data[0], 32'h33333333);

        // Disable: response of the previous grant still completes
        enable = 1'b0;
        #1 check("disabled gnt", 32'(gnt[0]), 32'h0);
        check("inflight r_valid", 32'(r_valid[0]), 32'h1);
        tick();
        check("disabled r_valid", 32'(r_valid[0]), 32'h0);
        enable = 1'b1;
        req = '0;

        // Range boundaries
        port_op(0, 1'b1, BASE + 32'(MEM), 4'hf, 32'h0);
        port_op(1, 1'b1, BASE + 32'(MEM - 4), 4'hf, 32'h0);
        port_op(2, 1'b1, BASE - 32'd4, 4'hf, 32'h0);
        tick();
        check("oor read", r_data[0], 32'h0);
        check("last word read", r_data[1], 32'h5d5c5b5a);
        check("below base read", r_data[2], 32'h0);
        req = '0;
        tick();

        // Reset in the middle of a read
        port_op(0, 1'b1, BASE, 4'hf, 32'h0);
        rst_n = 1'b0;
        tick();
        check("rst r_valid", 32'(r_valid[0]), 32'h0);
        check("rst cnt_rd", u_dut.cnt_rd[0], 32'h0);
        check("rst cnt_wr", u_dut.cnt_wr[0], 32'h0);
        rst_n = 1'b1;
        port_op(0, 1'b1, 32'h1c010000, 4'hf, 32'h0);
        tick();
        check("post-rst preload", r_data[0], stripe_word(0));
        port_op(0, 1'b1, BASE, 4'hf, 32'h0);
        tick();
        check("post-rst written", r_data[0], 32'h03BB01DD);

        // Randomized read data comes from the port LFSR
        tick();
        randomize = 1'b1;
        exp_rand = lfsr_m;
        tick();
        check("randomize r_data", r_data[0], exp_rand);
        randomize = 1'b0;
        req = '0;

        // Always-stalling instance
        s_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("stall gnt", 32'(s_gnt), 32'h0);
            tick();
        end
        check("stall r_valid", 32'(s_r_valid), 32'h0);
        s_stallable = 1'b0;
        #1 check("unstall gnt", 32'(s_gnt), 32'h1);
        tick();
        check("unstall r_valid", 32'(s_r_valid), 32'h1);
        s_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
